// File: rtl/stream_data_slicer.sv
// +----------------------------------------------------------------------------+
// | stream_data_slicer                                                         |
// | Splits wide input words into LSB-first slices with frame tracking and      |
// | address-counter update/clear strobes. Option macro: SLICER_PREFETCH_EN.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module stream_data_slicer #(
    parameter int InputDataWidth = 64,
    parameter int SliceWidth     = 8,
    parameter int NumSlices      = InputDataWidth / SliceWidth,
    parameter int SliceCntWidth  = $clog2(NumSlices + 1),
    parameter int CounterWidth   = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      clr_i,
    input  logic [SliceCntWidth-1:0]  cfg_num_slices_i,
    input  logic [CounterWidth-1:0]   cfg_frame_len_i,
    input  logic [InputDataWidth-1:0] data_i,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    output logic [SliceWidth-1:0]     slice_o,
    output logic                      slice_valid_o,
    input  logic                      slice_ready_i,
    output logic                      slice_last_o,
    output logic                      update_o,
    output logic                      clr_o,
    output logic [CounterWidth-1:0]   frame_cnt_o,
    output logic                      done_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SLICE = 1'b1
    } state_t;

    localparam logic [SliceCntWidth-1:0] MaxSlices = SliceCntWidth'(NumSlices);

    state_t                    state_q, state_d;
    logic [InputDataWidth-1:0] word_q, word_d;
    logic [InputDataWidth-1:0] word_shifted;
    logic [SliceCntWidth-1:0]  idx_q, idx_d;
    logic [SliceCntWidth-1:0]  eff_num;
    logic [CounterWidth-1:0]   frame_cnt_q, frame_cnt_d;
    logic                      clr_q, done_q;
    logic                      clear, hs, word_end, frame_end, leave, accept, ready;

`ifdef SLICER_PREFETCH_EN
    logic [InputDataWidth-1:0] buf_q, buf_d;
    logic                      buf_full_q, buf_full_d;
`endif

    // Out-of-range slice counts fall back to a full word.
    assign eff_num = ((cfg_num_slices_i == '0) || (cfg_num_slices_i > MaxSlices))
                   ? MaxSlices : cfg_num_slices_i;

    assign clear        = clr_i | ~en_i;
    assign word_shifted = word_q >> (idx_q * SliceWidth);

    assign slice_valid_o = (state_q == SLICE);
    assign slice_o       = word_shifted[SliceWidth-1:0];
    assign slice_last_o  = (cfg_frame_len_i != '0)
                         & (frame_cnt_q == cfg_frame_len_i - CounterWidth'(1))
                         & slice_valid_o;

    assign hs        = slice_valid_o & slice_ready_i & ~clear;
    assign word_end  = hs & (idx_q == eff_num - SliceCntWidth'(1));
    assign frame_end = hs & slice_last_o;
    assign leave     = word_end | frame_end;

`ifdef SLICER_PREFETCH_EN
    assign ready = ~buf_full_q & ~clear & rst_ni;
`else
    assign ready = (state_q == IDLE) & ~clear & rst_ni;
`endif
    assign accept = data_valid_i & ready;

    assign data_ready_o = ready;
    assign update_o     = hs;
    assign clr_o        = clr_q;
    assign done_o       = done_q;
    assign frame_cnt_o  = frame_cnt_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
`ifdef SLICER_PREFETCH_EN
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
`endif
        if (clear) begin
            state_d     = IDLE;
            word_d      = '0;
            idx_d       = '0;
            frame_cnt_d = '0;
`ifdef SLICER_PREFETCH_EN
            buf_d       = '0;
            buf_full_d  = 1'b0;
`endif
        end else begin
            if (hs) begin
                idx_d       = idx_q + SliceCntWidth'(1);
                frame_cnt_d = frame_end ? '0 : frame_cnt_q + CounterWidth'(1);
            end
`ifdef SLICER_PREFETCH_EN
            // A finished word is replaced in the same cycle, from the buffer first.
            if ((state_q == IDLE) || leave) begin
                if (buf_full_q) begin
                    word_d     = buf_q;
                    idx_d      = '0;
                    buf_full_d = 1'b0;
                    state_d    = SLICE;
                end else if (accept) begin
                    word_d  = data_i;
                    idx_d   = '0;
                    state_d = SLICE;
                end else begin
                    state_d = IDLE;
                end
            end else if (accept) begin
                buf_d      = data_i;
                buf_full_d = 1'b1;
            end
`else
            if (state_q == IDLE) begin
                if (accept) begin
                    word_d  = data_i;
                    idx_d   = '0;
                    state_d = SLICE;
                end
            end else if (leave) begin
                state_d = IDLE;
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            frame_cnt_q <= '0;
            clr_q       <= 1'b1;
            done_q      <= 1'b0;
`ifdef SLICER_PREFETCH_EN
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            clr_q       <= clear | frame_end;
            done_q      <= frame_end;
`ifdef SLICER_PREFETCH_EN
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stream_data_slicer.sv
// +----------------------------------------------------------------------------+
// | tb_stream_data_slicer                                                      |
// | Scoreboard bench for stream_data_slicer (honours SLICER_PREFETCH_EN).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_stream_data_slicer;

    logic        clk;
    logic        rst_ni;
    logic        en_i;
    logic        clr_i;
    logic [3:0]  cfg_num_slices_i;
    logic [31:0] cfg_frame_len_i;
    logic [63:0] data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic [7:0]  slice_o;
    logic        slice_valid_o;
    logic        slice_ready_i;
    logic        slice_last_o;
    logic        update_o;
    logic        clr_o;
    logic [31:0] frame_cnt_o;
    logic        done_o;

    stream_data_slicer dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .en_i             (en_i),
        .clr_i            (clr_i),
        .cfg_num_slices_i (cfg_num_slices_i),
        .cfg_frame_len_i  (cfg_frame_len_i),
        .data_i           (data_i),
        .data_valid_i     (data_valid_i),
        .data_ready_o     (data_ready_o),
        .slice_o          (slice_o),
        .slice_valid_o    (slice_valid_o),
        .slice_ready_i    (slice_ready_i),
        .slice_last_o     (slice_last_o),
        .update_o         (update_o),
        .clr_o            (clr_o),
        .frame_cnt_o      (frame_cnt_o),
        .done_o           (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Backpressure driver: one process owns slice_ready_i.
    logic rand_mode   = 1'b0;
    logic ready_force = 1'b0;
    always @(posedge clk) begin
        #2;
        slice_ready_i = rand_mode ? ($urandom_range(0, 1) == 1) : ready_force;
    end

    typedef struct {
        logic [7:0] s;
        logic       last;
    } exp_t;
    exp_t sb[$];

    logic        mon_en    = 1'b0;
    logic        exp_clr   = 1'b1;
    logic        exp_done  = 1'b0;
    logic [31:0] mon_cnt   = 0;
    logic [31:0] model_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_slice = 0;
    int          upd_n = 0, done_n = 0, cyc = 0, hs_n = 0, first_hs = 0, last_hs = 0;

    // Monitor: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic clear, hs, mlast;
            int   n;
            exp_t e;
            cyc++;
            clear = clr_i | ~en_i;
            hs    = slice_valid_o & slice_ready_i;
            mlast = (cfg_frame_len_i != 0) && (mon_cnt == cfg_frame_len_i - 1);
            chk("clr_o", clr_o, exp_clr);
            chk("done_o", done_o, exp_done);
            chk("frame_cnt_o", frame_cnt_o, mon_cnt);
            chk("update_o", update_o, hs & ~clear);
            if (prev_stall && slice_valid_o) chk("slice_stable", slice_o, prev_slice);
            if (done_o) done_n++;
            if (clear) begin
                sb.delete();
                mon_cnt   = 0;
                model_cnt = 0;
                exp_clr   = 1'b1;
                exp_done  = 1'b0;
            end else begin
                exp_clr  = 1'b0;
                exp_done = 1'b0;
                if (hs) begin
                    upd_n++;
                    if (hs_n == 0) first_hs = cyc;
                    hs_n++;
                    last_hs = cyc;
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL sb_underflow: got slice %0h expected none", slice_o);
                    end else begin
                        e = sb.pop_front();
                        chk("slice_o", slice_o, e.s);
                        chk("slice_last_o", slice_last_o, e.last);
                    end
                    if (mlast) begin
                        mon_cnt  = 0;
                        exp_done = 1'b1;
                        exp_clr  = 1'b1;
                    end else mon_cnt = mon_cnt + 1;
                end
                if (data_valid_i && data_ready_o) begin
                    n = (cfg_num_slices_i == 0 || cfg_num_slices_i > 8) ? 8 : int'(cfg_num_slices_i);
                    for (int i = 0; i < n; i++) begin
                        e.s    = data_i[i*8 +: 8];
                        e.last = (cfg_frame_len_i != 0) && (model_cnt == cfg_frame_len_i - 1);
                        sb.push_back(e);
                        if (e.last) begin
                            model_cnt = 0;
                            break;
                        end
                        model_cnt = model_cnt + 1;
                    end
                end
            end
            prev_stall = slice_valid_o & ~slice_ready_i & ~clear;
            prev_slice = slice_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    // Presents a word and returns just after the edge that accepts it; valid stays high.
    task automatic send(input logic [63:0] w);
        int t = 0;
        data_i       = w;
        data_valid_i = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!data_ready_o && t < 300);
        if (!data_ready_o) begin
            n_checks++;
            $display("FAIL send_timeout: got ready 0 expected 1");
        end
        tick();
    endtask

    task automatic drain();
        int t = 0;
        data_valid_i = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while (!(sb.size() == 0 && !slice_valid_o) && t < 1000);
        if (t >= 1000) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  num;
        logic [31:0] len;
        logic [63:0] data;
        int          exp_upd;
        int          exp_done;
    } vec_t;

    initial begin
        vec_t tbl[9];
        int   span;
        tbl[0] = '{4'd0,  32'd0, 64'h1122334455667788, 8, 0};
        tbl[1] = '{4'd1,  32'd0, 64'hA5A5A5A5A5A5A5C3, 1, 0};
        tbl[2] = '{4'd3,  32'd0, 64'hFFEEDDCCBBAA9988, 3, 0};
        tbl[3] = '{4'd8,  32'd0, 64'h0123456789ABCDEF, 8, 0};
        tbl[4] = '{4'd9,  32'd0, 64'hDEADBEEFCAFEF00D, 8, 0};
        tbl[5] = '{4'd15, 32'd0, 64'h13579BDF2468ACE0, 8, 0};
        tbl[6] = '{4'd5,  32'd3, 64'h5555AAAA3333CCCC, 3, 1};
        tbl[7] = '{4'd2,  32'd2, 64'h0F1E2D3C4B5A6978, 2, 1};
        tbl[8] = '{4'd4,  32'd6, 64'h8899AABBCCDDEEFF, 4, 0};

        rst_ni = 1'b0; en_i = 1'b1; clr_i = 1'b0;
        cfg_num_slices_i = 0; cfg_frame_len_i = 0;
        data_i = 0; data_valid_i = 1'b0; slice_ready_i = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data_ready", data_ready_o, 0);
        chk("rst_slice_valid", slice_valid_o, 0);
        chk("rst_update", update_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_frame_cnt", frame_cnt_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_data_ready", data_ready_o, 1);
        chk("post_rst_clr_o", clr_o, 1);
        tick();

        // Full word, no backpressure
        ready_force = 1'b1;
        pulse_clr();
        send(64'h0807060504030201);
        upd_n = 0;
        drain();
        chk("t2_frame_cnt", frame_cnt_o, 8);
        chk("t2_data_ready", data_ready_o, 1);

        // Configuration table
        foreach (tbl[k]) begin
            cfg_num_slices_i = tbl[k].num;
            cfg_frame_len_i  = tbl[k].len;
            pulse_clr();
            upd_n = 0; done_n = 0;
            send(tbl[k].data);
            drain();
            chk($sformatf("tbl%0d_updates", k), upd_n, tbl[k].exp_upd);
            chk($sformatf("tbl%0d_done", k), done_n, tbl[k].exp_done);
        end

        // Frame shorter than two words: 3 + 2 slices
        cfg_num_slices_i = 3; cfg_frame_len_i = 5;
        pulse_clr();
        upd_n = 0; done_n = 0;
        send(64'h00000000_00C0B0A0);
        send(64'h00000000_00F0E0D0);
        drain();
        chk("t3_updates", upd_n, 5);
        chk("t3_done", done_n, 1);
        chk("t3_frame_cnt", frame_cnt_o, 0);

        // Random backpressure
        cfg_num_slices_i = 0; cfg_frame_len_i = 0;
        pulse_clr();
        rand_mode = 1'b1;
        upd_n = 0;
        for (int w = 0; w < 4; w++) send({$urandom, $urandom});
        drain();
        rand_mode = 1'b0;
        chk("t4_updates", upd_n, 32);

        // Clear at slice index 4 with the handshake offered
        ready_force = 1'b0;
        pulse_clr();
        send(64'h7766554433221100);
        data_valid_i = 1'b0;
        ready_force  = 1'b1;
        repeat (4) tick();
        clr_i = 1'b1;
        @(negedge clk);
        chk("t5_update_in_clr", update_o, 0);
        chk("t5_valid_in_clr", slice_valid_o, 1);
        tick();
        clr_i = 1'b0;
        @(negedge clk);
        chk("t5_valid_after_clr", slice_valid_o, 0);
        chk("t5_frame_cnt", frame_cnt_o, 0);
        tick();
        send(64'hF7F6F5F4F3F2F1F0);
        drain();

        // Back-to-back words: bubble count between words
        pulse_clr();
        hs_n = 0;
        send(64'h1817161514131211);
        send(64'h2827262524232221);
        drain();
        span = last_hs - first_hs + 1;
        chk("t6_handshakes", hs_n, 16);
`ifdef SLICER_PREFETCH_EN
        chk("t6_span", span, 16);
`else
        chk("t6_span", span, 17);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
